// File: rtl/regfile_writeback_arbiter_if.sv
// regfile_writeback_arbiter_if: ALU/load result handshakes and register-file write port.
interface regfile_writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [31:0] wd;
  logic [4:0]  a3;
  logic        reg_write;
  logic [31:0] pending;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, wd, a3, reg_write, pending
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, wd, a3, reg_write, pending
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges ALU and queued load results onto the register-file write port.
// Optional WB_LOAD_BYPASS_EN lets a load hit the write port directly when nothing is queued.
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  regfile_writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]     rd_q   [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]  wp, rp;
  logic [AW:0]    count;
  logic [SW-1:0]  starve;
  logic [31:0]    wd, pend;
  logic [4:0]     a3;
  logic           reg_write;
  logic empty, full, force_pop, alu_wr, ld_acc, kill_ld, bypass, push, pop;
  assign empty     = count == '0;
  assign full      = count == (AW+1)'(DEPTH);
  assign force_pop = !empty && starve == SW'(STARVE_LIMIT);
  assign bus.alu_ready = en && !force_pop;
  assign bus.ld_ready  = en && !full;
  assign alu_wr  = bus.alu_valid && bus.alu_ready && bus.alu_rd != '0;
  assign ld_acc  = bus.ld_valid && bus.ld_ready;
  // a same-cycle ALU write is younger, so it supersedes a load to the same rd
  assign kill_ld = alu_wr && bus.alu_rd == bus.ld_rd;
`ifdef WB_LOAD_BYPASS_EN
  assign bypass  = ld_acc && bus.ld_rd != '0 && empty && !alu_wr;
`else
  assign bypass  = 1'b0;
`endif
  assign push = ld_acc && bus.ld_rd != '0 && !kill_ld && !bypass;
  assign pop  = en && !empty && !alu_wr;
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i]) pend[rd_q[i]] = 1'b1;
  end
  assign bus.pending   = pend;
  assign bus.wd        = wd;
  assign bus.a3        = a3;
  assign bus.reg_write = reg_write;
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wp]   <= bus.ld_rd;
      data_q[wp] <= bus.ld_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= '0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      starve    <= '0;
      wd        <= '0;
      a3        <= '0;
      reg_write <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alu_wr && rd_q[i] == bus.alu_rd) live_q[i] <= 1'b0;
      if (pop) begin
        live_q[rp] <= 1'b0;
        rp         <= rp + 1'b1;
      end
      if (push) begin
        live_q[wp] <= 1'b1;
        wp         <= wp + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (en) starve <= (empty || pop) ? '0 : (starve == SW'(STARVE_LIMIT) ? starve : starve + 1'b1);
      reg_write <= alu_wr || bypass || (pop && live_q[rp]);
      if (alu_wr) begin
        wd <= bus.alu_data;
        a3 <= bus.alu_rd;
      end else if (bypass) begin
        wd <= bus.ld_data;
        a3 <= bus.ld_rd;
      end else if (pop && live_q[rp]) begin
        wd <= data_q[rp];
        a3 <= rd_q[rp];
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed scenarios for the write-back arbiter.
module tb_regfile_writeback_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_writeback_arbiter_if bus ();
  regfile_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) u_dut (.clk(clk), .rst_n(rst_n), .en(en), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ld;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0);
    tick();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd11, 32'hA1);
    tick();
    idle();
    checks++;
    if (bus.pending !== 32'h0000_0C00) begin errors++; $display("FAIL reset_prefill_pending got %h want %h", bus.pending, 32'h0000_0C00); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.reg_write !== 1'b0 || bus.wd !== 32'd0 || bus.a3 !== 5'd0)
      begin errors++; $display("FAIL reset_outputs got rw=%b wd=%h a3=%0d want 0 0 0", bus.reg_write, bus.wd, bus.a3); end
    checks++;
    if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending got %h want 0", bus.pending); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready got ld=%b alu=%b want 1 1", bus.ld_ready, bus.alu_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL reset_no_write cycle %0d got rw=%b a3=%0d want rw=0", i, bus.reg_write, bus.a3); end
    end
  endtask

  task automatic test_alu_write;
    drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    tick();
    idle();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.a3 !== 5'd5 || bus.wd !== 32'h0000_1234)
      begin errors++; $display("FAIL alu_write got rw=%b a3=%0d wd=%h want 1 5 00001234", bus.reg_write, bus.a3, bus.wd); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0 || bus.wd !== 32'h0000_1234)
      begin errors++; $display("FAIL alu_pulse got rw=%b wd=%h want 0 00001234", bus.reg_write, bus.wd); end
  endtask

  task automatic test_load_latency;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    tick();
    idle();
`ifdef WB_LOAD_BYPASS_EN
    checks++;
    if (bus.reg_write !== 1'b1 || bus.a3 !== 5'd9 || bus.wd !== 32'h99 || bus.pending !== 32'd0)
      begin errors++; $display("FAIL bypass_n1 got rw=%b a3=%0d wd=%h pend=%h want 1 9 99 0", bus.reg_write, bus.a3, bus.wd, bus.pending); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL bypass_pulse got rw=%b want 0", bus.reg_write); end
`else
    checks++;
    if (bus.reg_write !== 1'b0 || bus.pending !== 32'h0000_0200)
      begin errors++; $display("FAIL load_n1 got rw=%b pend=%h want 0 00000200", bus.reg_write, bus.pending); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.a3 !== 5'd9 || bus.wd !== 32'h99 || bus.pending !== 32'd0)
      begin errors++; $display("FAIL load_n2 got rw=%b a3=%0d wd=%h pend=%h want 1 9 99 0", bus.reg_write, bus.a3, bus.wd, bus.pending); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL load_pulse got rw=%b want 0", bus.reg_write); end
`endif
  endtask

  task automatic test_starve;
    int idx = 0;
    logic saw_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(2 + i), 32'hD0 + i);
      #1;
      checks++;
      if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL starve_fill_ready load %0d got %b want 1", i, bus.ld_ready); end
      tick();
    end
    drive(1'b1, 5'd1, 32'h200, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.pending !== 32'h0000_003C)
      begin errors++; $display("FAIL starve_full got ld_ready=%b pend=%h want 0 0000003c", bus.ld_ready, bus.pending); end
    for (int c = 0; c < 40 && idx < 4; c++) begin
      if (bus.alu_ready === 1'b0) saw_stall = 1'b1;
      tick();
      if (bus.reg_write === 1'b1 && bus.a3 !== 5'd1) begin
        checks++;
        if (bus.a3 !== 5'(2 + idx) || bus.wd !== 32'hD0 + idx)
          begin errors++; $display("FAIL starve_drain %0d got a3=%0d wd=%h want %0d %h", idx, bus.a3, bus.wd, 2 + idx, 32'hD0 + idx); end
        idx++;
      end
    end
    checks++;
    if (idx !== 4) begin errors++; $display("FAIL starve_drain_count got %0d want 4", idx); end
    checks++;
    if (saw_stall !== 1'b1) begin errors++; $display("FAIL starve_force got alu_ready_low=%b want 1", saw_stall); end
    idle();
    tick();
    tick();
    checks++;
    if (bus.pending !== 32'd0) begin errors++; $display("FAIL starve_pending_clear got %h want 0", bus.pending); end
  endtask

  task automatic test_kill;
    logic wrote = 1'b0;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h55);
    tick();
    drive(1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.pending !== 32'h0000_0080) begin errors++; $display("FAIL kill_queued got pend=%h want 00000080", bus.pending); end
    tick();
    idle();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.a3 !== 5'd7 || bus.wd !== 32'hAA || bus.pending !== 32'd0)
      begin errors++; $display("FAIL kill_alu got rw=%b a3=%0d wd=%h pend=%h want 1 7 aa 0", bus.reg_write, bus.a3, bus.wd, bus.pending); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.reg_write === 1'b1) wrote = 1'b1;
    end
    checks++;
    if (wrote !== 1'b0 || bus.wd !== 32'hAA) begin errors++; $display("FAIL kill_no_pop_write got wrote=%b wd=%h want 0 aa", wrote, bus.wd); end
  endtask

  task automatic test_zero;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1)
      begin errors++; $display("FAIL zero_ready got alu=%b ld=%b want 1 1", bus.alu_ready, bus.ld_ready); end
    tick();
    idle();
    checks++;
    if (bus.reg_write !== 1'b0 || bus.pending !== 32'd0)
      begin errors++; $display("FAIL zero_n1 got rw=%b pend=%h want 0 0", bus.reg_write, bus.pending); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL zero_n2 got rw=%b want 0", bus.reg_write); end
  endtask

  task automatic test_enable;
    drive(1'b1, 5'd1, 32'h3, 1'b1, 5'd12, 32'hC0);
    tick();
    drive(1'b1, 5'd1, 32'h3, 1'b1, 5'd13, 32'hC1);
    tick();
    drive(1'b1, 5'd2, 32'h77, 1'b1, 5'd14, 32'hC2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.ld_ready !== 1'b0 || bus.alu_ready !== 1'b0)
        begin errors++; $display("FAIL en_ready cycle %0d got ld=%b alu=%b want 0 0", i, bus.ld_ready, bus.alu_ready); end
      tick();
      checks++;
      if (bus.reg_write !== 1'b0 || bus.wd !== 32'h3 || bus.pending !== 32'h0000_3000)
        begin errors++; $display("FAIL en_freeze cycle %0d got rw=%b wd=%h pend=%h want 0 3 00003000", i, bus.reg_write, bus.wd, bus.pending); end
    end
    idle();
    en = 1'b1;
    tick();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.a3 !== 5'd12 || bus.wd !== 32'hC0)
      begin errors++; $display("FAIL en_drain0 got rw=%b a3=%0d wd=%h want 1 12 c0", bus.reg_write, bus.a3, bus.wd); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b1 || bus.a3 !== 5'd13 || bus.wd !== 32'hC1)
      begin errors++; $display("FAIL en_drain1 got rw=%b a3=%0d wd=%h want 1 13 c1", bus.reg_write, bus.a3, bus.wd); end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0 || bus.pending !== 32'd0)
      begin errors++; $display("FAIL en_done got rw=%b pend=%h want 0 0", bus.reg_write, bus.pending); end
  endtask

  initial begin
    idle();
    repeat (2) tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    test_reset();
    test_alu_write();
    test_load_latency();
    test_starve();
    test_kill();
    test_zero();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
